// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock/tick divider with double-buffered settings.
// Settings take effect only at period boundaries, on sync, or while disabled.
module clock_divider_bank #(
    parameter int channels     = 4,
    parameter int divider_bits = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [channels-1:0]            enable,
    input  logic [channels*divider_bits-1:0] period,
    input  logic [channels*divider_bits-1:0] high_time,
    input  logic                           load,
    input  logic                           sync,
    output logic [channels-1:0]            clk_out,
    output logic [channels-1:0]            tick,
    output logic [channels-1:0]            pending
);

    localparam int W = divider_bits;

    for (genvar i = 0; i < channels; i++) begin : g_ch
        logic [W-1:0] p_in;
        logic [W-1:0] h_in;
        logic [W-1:0] cnt_q;
        logic [W-1:0] cnt_d;
        logic [W-1:0] pa_q;
        logic [W-1:0] pa_d;
        logic [W-1:0] ha_q;
        logic [W-1:0] ha_d;
        logic [W-1:0] ps_q;
        logic [W-1:0] hs_q;
        logic         run_q;
        logic         pend_q;
        logic         pend_d;
        logic         clk_q;
        logic         tick_q;
        logic         wrap;
        logic         restart;

        assign p_in    = period[i*W +: W];
        assign h_in    = high_time[i*W +: W];
        assign wrap    = run_q && (cnt_q == pa_q);
        assign restart = sync && enable[i];

        // A load coinciding with a wrap or sync bypasses the shadow so the
        // new period starts with the new values; while disabled the shadow
        // is applied one cycle after capture.
        always_comb begin
            pa_d   = pa_q;
            ha_d   = ha_q;
            pend_d = pend_q;
            if (wrap || restart) begin
                pa_d   = load ? p_in : ps_q;
                ha_d   = load ? h_in : hs_q;
                pend_d = 1'b0;
            end else if (load) begin
                pend_d = 1'b1;
            end else if (!run_q && pend_q) begin
                pa_d   = ps_q;
                ha_d   = hs_q;
                pend_d = 1'b0;
            end
            if (!enable[i] || !run_q || wrap || restart) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q  <= '0;
                pa_q   <= '0;
                ha_q   <= '0;
                ps_q   <= '0;
                hs_q   <= '0;
                run_q  <= 1'b0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                pa_q   <= pa_d;
                ha_q   <= ha_d;
                pend_q <= pend_d;
                run_q  <= enable[i];
                if (load) begin
                    ps_q <= p_in;
                    hs_q <= h_in;
                end
                clk_q  <= enable[i] && (cnt_d < ha_d);
                tick_q <= enable[i] && (cnt_d == pa_d);
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule
